pdm_mic_clap_detector: RTL and testbench



---
 rtl/pdm_mic_clap_detector.sv | 136 +++++++++++++
 tb/tb_pdm_mic_clap_detector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_clap_detector.sv
// PDM microphone front end: drives M_CLK, counts ones per window into PCM samples and an
// amplitude level, and strobes clap_pulse after consecutive loud windows.
module pdm_mic_clap_detector #(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter int unsigned THRESHOLD   = 48,
  parameter int unsigned MIN_HITS    = 2,
  parameter int unsigned HOLDOFF     = 2000
) (
  input  logic                   pulse_5MHz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   M_DATA,
  output logic                   M_CLK,
  output logic                   M_LR_SEL,
  output logic [WINDOW_LOG2:0]   pcm_sample,
  output logic                   sample_valid,
  output logic [WINDOW_LOG2-1:0] level,
  output logic                   clap_pulse,
  output logic                   busy_holdoff
);

  localparam int unsigned DivW  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned HitW  = (MIN_HITS > 1) ? $clog2(MIN_HITS + 1) : 1;
  localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam int unsigned SampW = WINDOW_LOG2 + 1;

  localparam logic [DivW-1:0]        DivLast  = DivW'(HALF_PERIOD - 1);
  localparam logic [WINDOW_LOG2-1:0] BitLast  = '1;
  localparam logic [SampW-1:0]       Mid      = SampW'(1 << (WINDOW_LOG2 - 1));
  localparam logic [SampW-1:0]       Thresh   = SampW'(THRESHOLD);
  localparam logic [HitW-1:0]        HitsLast = HitW'(MIN_HITS - 1);
  localparam logic [HoldW-1:0]       HoldInit = HoldW'(HOLDOFF);

  logic [DivW-1:0]        div_q, div_d;
  logic                   m_clk_q, m_clk_d;
  logic [WINDOW_LOG2-1:0] bit_cnt_q, bit_cnt_d;
  logic [SampW-1:0]       acc_q, acc_d;
  logic [SampW-1:0]       pcm_q, pcm_d;
  logic [WINDOW_LOG2-1:0] level_q, level_d;
  logic                   valid_q, valid_d;
  logic                   clap_q, clap_d;
  logic [HitW-1:0]        hits_q, hits_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic                   busy_q, busy_d;

  logic             div_tc, strobe, window_done, hit;
  logic [SampW-1:0] pcm_new, level_wide;

  always_comb begin
    div_tc      = (div_q == DivLast);
    // Data is taken on the M_CLK falling transition, one bit per M_CLK period.
    strobe      = m_clk_q & div_tc;
    window_done = strobe & (bit_cnt_q == BitLast);
    pcm_new     = acc_q + SampW'(M_DATA);
    level_wide  = (pcm_new >= Mid) ? (pcm_new - Mid) : (Mid - pcm_new);
    hit         = (level_wide > Thresh);
  end

  always_comb begin
    div_d     = div_tc ? '0 : div_q + DivW'(1);
    m_clk_d   = m_clk_q ^ div_tc;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    pcm_d     = pcm_q;
    level_d   = level_q;
    valid_d   = 1'b0;
    clap_d    = 1'b0;
    hits_d    = hits_q;
    hold_d    = hold_q;

    if (strobe) begin
      bit_cnt_d = bit_cnt_q + WINDOW_LOG2'(1);
      acc_d     = pcm_new;
    end

    if (window_done) begin
      acc_d   = '0;
      pcm_d   = pcm_new;
      level_d = level_wide[WINDOW_LOG2-1:0];
      valid_d = 1'b1;
      if (hold_q != '0) begin
        hold_d = hold_q - HoldW'(1);
        hits_d = '0;
      end else if (hit && (hits_q == HitsLast)) begin
        clap_d = 1'b1;
        hold_d = HoldInit;
        hits_d = '0;
      end else if (hit) begin
        hits_d = hits_q + HitW'(1);
      end else begin
        hits_d = '0;
      end
    end

    busy_d = (hold_d != '0);
  end

  // Disabling behaves exactly like reset so a partial window is discarded.
  always_ff @(posedge pulse_5MHz) begin
    if (reset || !enable) begin
      div_q     <= '0;
      m_clk_q   <= 1'b0;
      bit_cnt_q <= '0;
      acc_q     <= '0;
      pcm_q     <= '0;
      level_q   <= '0;
      valid_q   <= 1'b0;
      clap_q    <= 1'b0;
      hits_q    <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      m_clk_q   <= m_clk_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
      pcm_q     <= pcm_d;
      level_q   <= level_d;
      valid_q   <= valid_d;
      clap_q    <= clap_d;
      hits_q    <= hits_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
    end
  end

  assign M_CLK        = m_clk_q;
  assign M_LR_SEL     = 1'b0;
  assign pcm_sample   = pcm_q;
  assign sample_valid = valid_q;
  assign level        = level_q;
  assign clap_pulse   = clap_q;
  assign busy_holdoff = busy_q;

endmodule

// File: tb/tb_pdm_mic_clap_detector.sv
// Bench for pdm_mic_clap_detector: directed scenarios plus random PDM density, checked every
// cycle against a window/queue reference model.
module tb_pdm_mic_clap_detector;

  localparam int HP   = 2;
  localparam int WL   = 4;
  localparam int THR  = 3;
  localparam int MH   = 2;
  localparam int HO   = 6;
  localparam int WIN  = 1 << WL;
  localparam int HALF = WIN / 2;
  localparam int WCYC = 2 * HP * WIN;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          m_data = 1'b0;
  logic          m_clk, m_lr_sel, sample_valid, clap_pulse, busy_holdoff;
  logic [WL:0]   pcm_sample;
  logic [WL-1:0] level;

  pdm_mic_clap_detector #(
    .HALF_PERIOD(HP),
    .WINDOW_LOG2(WL),
    .THRESHOLD  (THR),
    .MIN_HITS   (MH),
    .HOLDOFF    (HO)
  ) dut (
    .pulse_5MHz  (clk),
    .reset       (reset),
    .enable      (enable),
    .M_DATA      (m_data),
    .M_CLK       (m_clk),
    .M_LR_SEL    (m_lr_sel),
    .pcm_sample  (pcm_sample),
    .sample_valid(sample_valid),
    .level       (level),
    .clap_pulse  (clap_pulse),
    .busy_holdoff(busy_holdoff)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: time since enable, bits of the current window, detector.
  int n = 0;
  int bits[$];
  int m_hits = 0, m_hold = 0;
  int e_mclk = 0, e_pcm = 0, e_valid = 0, e_level = 0, e_clap = 0, e_busy = 0;

  // Stimulus: 0 zeros, 1 ones, 2 alternate per bit, 3 fixed ones count, 4 random bits.
  int mode = 0;
  int ones_target = 0;
  bit alt_bit = 1'b0;
  bit rand_target = 1'b0;

  int win_seen = 0;
  int clap_wins[$];

  task automatic step(input bit rst, input bit en);
    bit d;
    int pcm, lvl;
    case (mode)
      0:       d = 1'b0;
      1:       d = 1'b1;
      2:       d = alt_bit;
      3:       d = (bits.size() < ones_target);
      default: d = 1'($urandom_range(0, 1));
    endcase
    reset  = rst;
    enable = en;
    m_data = d;
    @(posedge clk);
    #1;
    e_valid = 0;
    e_clap  = 0;
    if (rst || !en) begin
      n = 0;
      bits.delete();
      m_hits = 0;
      m_hold = 0;
      e_mclk = 0;
      e_pcm = 0;
      e_level = 0;
      e_busy = 0;
    end else begin
      // M_CLK is high in the second half of each 2*HP period; data taken at its last cycle.
      if ((n % (2 * HP)) == (2 * HP - 1)) begin
        bits.push_back(int'(d));
        alt_bit = !alt_bit;
        if (bits.size() == WIN) begin
          pcm = 0;
          foreach (bits[i]) pcm += bits[i];
          lvl = (pcm >= HALF) ? pcm - HALF : HALF - pcm;
          e_pcm = pcm;
          e_level = lvl;
          e_valid = 1;
          if (m_hold > 0) begin
            m_hold--;
            m_hits = 0;
          end else if (lvl > THR) begin
            m_hits++;
            if (m_hits == MH) begin
              e_clap = 1;
              m_hold = HO;
              m_hits = 0;
            end
          end else begin
            m_hits = 0;
          end
          bits.delete();
          if (rand_target) ones_target = int'($urandom_range(0, WIN));
        end
      end
      n++;
      e_mclk = (n / HP) % 2;
      e_busy = (m_hold != 0) ? 1 : 0;
    end
    if (sample_valid) begin
      win_seen++;
      if (clap_pulse) clap_wins.push_back(win_seen);
    end
    check_value("m_clk", int'(m_clk), e_mclk);
    check_value("m_lr_sel", int'(m_lr_sel), 0);
    check_value("sample_valid", int'(sample_valid), e_valid);
    check_value("pcm_sample", int'(pcm_sample), e_pcm);
    check_value("level", int'(level), e_level);
    check_value("clap_pulse", int'(clap_pulse), e_clap);
    check_value("busy_holdoff", int'(busy_holdoff), e_busy);
  endtask

  task automatic run_windows(input int w);
    repeat (w * WCYC) step(1'b0, 1'b1);
  endtask

  task automatic clear_obs();
    win_seen = 0;
    clap_wins.delete();
  endtask

  // Counts enabled cycles until the first sample_valid; bounded.
  task automatic measure_latency(input string tag);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 4 * WCYC) begin
      step(1'b0, 1'b1);
      cyc++;
      seen = sample_valid;
    end
    check_value(tag, seen ? cyc : -1, WCYC);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0);

    // Silence: level maxes out, claps at window MH and after the holdoff.
    mode = 0;
    clear_obs();
    measure_latency("first_window_latency");
    run_windows(11);
    check_value("silence_clap_count", clap_wins.size(), 2);
    check_value("silence_clap1_window", clap_wins.size() > 0 ? clap_wins[0] : -1, MH);
    check_value("silence_clap2_window", clap_wins.size() > 1 ? clap_wins[1] : -1, MH + HO + MH);

    // Alternating bits: pcm at midpoint, never a clap.
    step(1'b1, 1'b1);
    mode = 2;
    alt_bit = 1'b0;
    clear_obs();
    run_windows(10);
    check_value("alt_window_count", win_seen, 10);
    check_value("alt_clap_count", clap_wins.size(), 0);

    // All ones: full-scale count without wrap.
    step(1'b1, 1'b1);
    mode = 1;
    run_windows(1);
    check_value("all_ones_pcm", int'(pcm_sample), WIN);

    // One loud window then quiet: hit count must restart.
    step(1'b1, 1'b1);
    mode = 0;
    clear_obs();
    run_windows(1);
    mode = 2;
    run_windows(3);
    check_value("reset_hits_clap_count", clap_wins.size(), 0);

    // Level exactly at threshold on both sides: strict compare, no clap.
    mode = 3;
    ones_target = HALF + THR;
    clear_obs();
    run_windows(5);
    ones_target = HALF - THR;
    run_windows(5);
    check_value("at_threshold_clap_count", clap_wins.size(), 0);
    ones_target = HALF + THR + 1;
    run_windows(2);
    check_value("above_threshold_clap_count", clap_wins.size(), 1);

    // Enable dropped mid-window: partial window discarded, full latency after re-enable.
    step(1'b1, 1'b1);
    mode = 4;
    repeat (WCYC + WCYC / 2 + 3) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    measure_latency("reenable_latency");

    // Reset during holdoff: busy clears, fresh clap after MH windows.
    step(1'b1, 1'b1);
    mode = 0;
    run_windows(3);
    check_value("holdoff_busy", int'(busy_holdoff), 1);
    step(1'b1, 1'b1);
    check_value("busy_after_reset", int'(busy_holdoff), 0);
    clear_obs();
    run_windows(MH);
    check_value("post_reset_clap_window", clap_wins.size() > 0 ? clap_wins[0] : -1, MH);

    // Random densities with occasional resets and enable drops.
    mode = 3;
    rand_target = 1'b1;
    ones_target = int'($urandom_range(0, WIN));
    repeat (150 * WCYC) step($urandom_range(0, 1999) == 0, $urandom_range(0, 999) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
